vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator: free-running horizontal/vertical counters with pixel clock-enable, configurable porch/sync geometry and sync polarity, active-area-relative pixel coordinates, and single-cycle line/frame start strobes. Sits between the system clock and the pixel/renderer pipeline (paddle, ball, score overlay); it drives the board VGA sync pins and tells the renderer which pixel to produce.

## Interface
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 12, counter/coordinate width; must satisfy 2^CW > max(H total, V total)
- PIPE_DLY, 2, sync/active delay stages (used only with VGA_TIMING_DELAY_EN)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- ce  in  1  pixel clock enable; counters advance only when 1
- h_cnt  out  CW  raw horizontal count, 0..H_TOT-1
- v_cnt  out  CW  raw vertical count, 0..V_TOT-1
- x  out  CW  active-relative column, 0..H_ACT-1; 0 outside active
- y  out  CW  active-relative row, 0..V_ACT-1; 0 outside active
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- active  out  1  pixel in visible area
- line_start  out  1  one-cycle strobe, h wrap
- frame_start  out  1  one-cycle strobe, h and v wrap
- vblank  out  1  v_cnt outside active lines

## Operation
- H_TOT = H_SYNC+H_BP+H_ACT+H_FP; V_TOT likewise. Line order: sync, back porch, active, front porch.
- ce=1: h_cnt increments; at H_TOT-1 wraps to 0 and v_cnt increments; v_cnt at V_TOT-1 with h wrap goes to 0. ce=0: all state and outputs hold, strobes forced 0.
- hsync = HS_POL while h_cnt < H_SYNC, else ~HS_POL; vsync analogous on v_cnt.
- Active horizontal window: H_SYNC+H_BP ≤ h_cnt ≤ H_SYNC+H_BP+H_ACT-1 (inclusive, exactly H_ACT pixels). Vertical analogous, exactly V_ACT lines.
- x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) when active, else 0; unsigned, CW bits, no wrap possible.
- line_start: 1 for the one ce cycle in which h_cnt becomes 0. frame_start: same, when h_cnt and v_cnt both become 0.

## Timing
- All outputs registered, decoded from next-count values, so every output is consistent with h_cnt/v_cnt in the same cycle; zero latency between counters and decodes.
- Reset (rst=0 at clk edge): h_cnt=v_cnt=0, x=y=0, active=0, vblank=1, line_start=frame_start=0, hsync=HS_POL, vsync=VS_POL. First frame after reset is not flagged by frame_start; the next wrap is.
- Reset mid-line overrides ce and any counter state on that edge.
- ce toggling every cycle halves pixel rate; strobes remain one clk wide.

## Configuration
- VGA_TIMING_DELAY_EN defined: hsync, vsync, active delayed PIPE_DLY ce-qualified stages (reset to idle levels above) to align with renderer pipeline latency; x, y, counters, strobes undelayed.
- Undefined: no delay stages; PIPE_DLY ignored; all outputs aligned as in Timing.

## Structure
- Package vga_pkg: default 640x480@60 timing constants, H_TOT/V_TOT derivation functions, polarity constants.
- Sub-module vga_sync_delay: PIPE_DLY-deep, ce-qualified shift register, with reset value ports, instantiated only under VGA_TIMING_DELAY_EN.

## Test plan
- Reset, ce=1 constant -> hsync=0 for h_cnt 0..95, 1 from 96; line_start every 800 clk; frame_start every 420000 clk.
- Active check -> active first at h_cnt=144/v_cnt=35 with x=0,y=0; last at h_cnt=783/v_cnt=514 with x=639,y=479; exactly 307200 active cycles per frame.
- ce toggling 1,0,1,0 -> counters advance every other clk; line_start period 1600 clk, width 1 clk.
- Assert rst at h_cnt=400,v_cnt=200 -> next cycle all outputs at reset values; release -> h_cnt counts 0,1,2.
- HS_POL=1, VS_POL=1, 800x600 params (128/88/800/40, 4/23/600/1) -> hsync high for 128 pixels, H_TOT=1056, V_TOT=628, vsync high 4 lines.
- VGA_TIMING_DELAY_EN, PIPE_DLY=2 -> active and syncs lag undelayed versions by exactly 2 ce cycles; x/y unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers: default 640x480@60 geometry,
// sync polarity encodings and the line/frame total derivation.
package vga_pkg;

    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;

    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    localparam bit DEF_HS_POL = POL_LOW;
    localparam bit DEF_VS_POL = POL_LOW;

    // Segment order inside a line/frame is sync, back porch, active, front porch.
    function automatic int h_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int v_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable-qualified shift register that retimes sync/active signals to
// match the renderer pipeline depth; each stage resets to a supplied idle value.
module vga_sync_delay #(
    parameter int W   = 3,
    parameter int DLY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] i_d,
    input  logic [W-1:0] i_rst_val,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_pipe [DLY];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) begin
                r_pipe[i] <= i_rst_val;
            end
        end else if (ce) begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DLY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DLY-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered, next-count-decoded outputs.
// Optional sync/active retiming stages are enabled by VGA_TIMING_DELAY_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int V_FP     = DEF_V_FP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int CW       = 12,
    parameter int PIPE_DLY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    localparam int H_TOT = h_total(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int V_TOT = v_total(V_SYNC, V_BP, V_ACT, V_FP);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BP + H_ACT - 1);

    localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BP + V_ACT - 1);

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_vblank;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_act;
    logic          w_v_act;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;

    // Decode from the counts the registers are about to take so that every
    // registered output lines up with h_cnt/v_cnt in the same cycle.
    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_v_wrap = (r_v_cnt == V_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + CW'(1);
        w_v_nxt  = r_v_cnt;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v_cnt + CW'(1);
        end
        w_h_act = (w_h_nxt >= H_ACT_BEG) && (w_h_nxt <= H_ACT_END);
        w_v_act = (w_v_nxt >= V_ACT_BEG) && (w_v_nxt <= V_ACT_END);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= HS_POL;
            r_vsync       <= VS_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank      <= 1'b1;
        end else if (ce) begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_x           <= (w_h_act && w_v_act) ? (w_h_nxt - H_ACT_BEG) : '0;
            r_y           <= (w_h_act && w_v_act) ? (w_v_nxt - V_ACT_BEG) : '0;
            r_hsync       <= (w_h_nxt < H_SYNC_END) ? HS_POL : ~HS_POL;
            r_vsync       <= (w_v_nxt < V_SYNC_END) ? VS_POL : ~VS_POL;
            r_active      <= w_h_act && w_v_act;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
            r_vblank      <= ~w_v_act;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign vblank      = r_vblank;

`ifdef VGA_TIMING_DELAY_EN
    logic [2:0] w_sync_dly;

    vga_sync_delay #(
        .W   (3),
        .DLY (PIPE_DLY)
    ) u_sync_delay (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .i_d       ({r_hsync, r_vsync, r_active}),
        .i_rst_val ({HS_POL, VS_POL, 1'b0}),
        .o_q       (w_sync_dly)
    );

    assign {hsync, vsync, active} = w_sync_dly;
`else
    // Without retiming the stage count has no effect.
    logic [31:0] w_unused_pipe_dly;
    assign w_unused_pipe_dly = 32'(PIPE_DLY);

    assign hsync  = r_hsync;
    assign vsync  = r_vsync;
    assign active = r_active;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster geometry with mixed
// sync polarities; follows VGA_TIMING_DELAY_EN when it is defined.
module tb_vga_timing_gen;

    localparam int CW       = 8;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int H_ACT    = 8;
    localparam int H_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int V_ACT    = 4;
    localparam int V_FP     = 2;
    localparam bit HS_POL   = 1'b1;
    localparam bit VS_POL   = 1'b0;
    localparam int PIPE_DLY = 2;

    localparam int H_TOT = 15;
    localparam int V_TOT = 9;
    localparam int HA0   = H_SYNC + H_BP;
    localparam int VA0   = V_SYNC + V_BP;
    localparam int W     = 4 * CW + 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce  = 1'b0;
    logic [CW-1:0] h_cnt, v_cnt, x, y;
    logic          hsync, vsync, active, line_start, frame_start, vblank;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .PIPE_DLY(PIPE_DLY)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .active(active),
        .line_start(line_start), .frame_start(frame_start), .vblank(vblank)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    int   m_h = 0;
    int   m_v = 0;
    logic m_ls = 1'b0;
    logic m_fs = 1'b0;
    logic [2:0] m_dly [PIPE_DLY];

    int   exp_ls_period = 0;
    int   last_ls = -1;
    int   act_cnt = 0;
    logic seen_fs = 1'b0;
    logic chk_frame = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic in_h(input int h);
        return (h >= HA0) && (h < HA0 + H_ACT);
    endfunction

    function automatic logic in_v(input int v);
        return (v >= VA0) && (v < VA0 + V_ACT);
    endfunction

    function automatic logic [2:0] model_sync(input int h, input int v);
        logic hs, vs;
        hs = (h < H_SYNC) ? HS_POL : ~HS_POL;
        vs = (v < V_SYNC) ? VS_POL : ~VS_POL;
        return {hs, vs, in_h(h) && in_v(v)};
    endfunction

    task automatic monitor_cycle();
        logic [W-1:0] e;
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_eq("h_cnt",       h_cnt,       e[W-1 -: CW]);
        check_eq("v_cnt",       v_cnt,       e[W-1-CW -: CW]);
        check_eq("x",           x,           e[W-1-2*CW -: CW]);
        check_eq("y",           y,           e[W-1-3*CW -: CW]);
        check_eq("hsync",       hsync,       e[5]);
        check_eq("vsync",       vsync,       e[4]);
        check_eq("active",      active,      e[3]);
        check_eq("line_start",  line_start,  e[2]);
        check_eq("frame_start", frame_start, e[1]);
        check_eq("vblank",      vblank,      e[0]);
        if (exp_ls_period > 0 && line_start) begin
            if (last_ls >= 0) check_eq("ls_period", cyc - last_ls, exp_ls_period);
            last_ls = cyc;
        end
        if (chk_frame) begin
            if (frame_start) begin
                if (seen_fs) check_eq("act_per_frame", act_cnt, H_ACT * V_ACT);
                act_cnt = 0;
                seen_fs = 1'b1;
            end
            if (active) act_cnt++;
        end
    endtask

    task automatic drive_cycle(input logic r, input logic c);
        logic [2:0]    s_old, s_new;
        logic [CW-1:0] ex, ey;
        logic          vb;
        rst = r;
        ce  = c;
        s_old = model_sync(m_h, m_v);
        if (!r) begin
            m_h = 0; m_v = 0; m_ls = 1'b0; m_fs = 1'b0;
            for (int i = 0; i < PIPE_DLY; i++) m_dly[i] = {HS_POL, VS_POL, 1'b0};
        end else if (c) begin
            for (int i = PIPE_DLY - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
            m_dly[0] = s_old;
            m_h++;
            if (m_h == H_TOT) begin
                m_h = 0;
                m_v++;
                if (m_v == V_TOT) m_v = 0;
            end
            m_ls = (m_h == 0);
            m_fs = m_ls && (m_v == 0);
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
        s_new = model_sync(m_h, m_v);
`ifdef VGA_TIMING_DELAY_EN
        s_new = m_dly[PIPE_DLY-1];
`endif
        ex = (in_h(m_h) && in_v(m_v)) ? CW'(m_h - HA0) : '0;
        ey = (in_h(m_h) && in_v(m_v)) ? CW'(m_v - VA0) : '0;
        vb = ~in_v(m_v);
        exp_q.push_back({CW'(m_h), CW'(m_v), ex, ey, s_new, m_ls, m_fs, vb});
        @(posedge clk);
        #1;
        cyc++;
        monitor_cycle();
    endtask

    initial begin
        // Reset with ce noise: reset must dominate.
        repeat (3) drive_cycle(1'b0, 1'($urandom_range(0, 1)));

        // Continuous pixel enable: line period, active pixels per frame.
        exp_ls_period = H_TOT;
        chk_frame     = 1'b1;
        repeat (3 * H_TOT * V_TOT + 5) drive_cycle(1'b1, 1'b1);

        // Half-rate pixel enable: doubled line period, one-clock strobes.
        chk_frame     = 1'b0;
        exp_ls_period = 2 * H_TOT;
        last_ls       = -1;
        for (int i = 0; i < 8 * H_TOT; i++) drive_cycle(1'b1, 1'((i % 2) == 0));

        // Random enable with occasional resets.
        exp_ls_period = 0;
        repeat (600) drive_cycle(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0));

        // Reset in the middle of an active line, then count up again.
        drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 200 && !(m_h == 7 && m_v == 4); i++) drive_cycle(1'b1, 1'b1);
        check_eq("mid_line_h", h_cnt, 7);
        drive_cycle(1'b0, 1'b1);
        repeat (5) drive_cycle(1'b1, 1'b1);

        check_eq("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
